// File: rtl/vga_draw_scheduler.sv
// Single owner of the VGA write port: arbitrates three pixel requesters and runs a black clear sweep.
// Define ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module vga_draw_scheduler #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int COLOUR_W = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clr_start,
   input  logic [2:0]            req,
   input  logic [23:0]           req_x,
   input  logic [20:0]           req_y,
   input  logic [3*COLOUR_W-1:0] req_colour,
   output logic [2:0]            ack,
   output logic [7:0]            x,
   output logic [6:0]            y,
   output logic [COLOUR_W-1:0]   colour,
   output logic                  plot,
   output logic                  busy,
   output logic                  clear_done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
   localparam logic [6:0] Y_MAX = 7'(SCREEN_H - 1);

   logic [1:0]          state;
   logic [2:0]          elig;
   logic [2:0]          gnt;
   logic [1:0]          gi;
   logic [7:0]          sel_x;
   logic [6:0]          sel_y;
   logic [COLOUR_W-1:0] sel_c;
   logic                in_range;

   // A grant is followed by one quiet cycle, so a req still held
   // during its ack cycle can never be served twice.
   assign elig = (|ack) ? 3'b000 : req;

`ifdef ROUND_ROBIN_EN
   logic [1:0] ptr;
   logic [1:0] j;

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   always_comb begin
      gnt = '0;
      gi  = '0;
      j   = '0;
      for (int k = 2; k >= 0; k--) begin
         j = wrap3(3'(ptr) + 3'(k));
         if (elig[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            gi     = j;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if ((state != S_CLEAR) && !(state == S_IDLE && clr_start) && (|gnt)) begin
         ptr <= (gi == 2'd2) ? 2'd0 : gi + 2'd1;
      end
   end
`else
   always_comb begin
      gnt = '0;
      gi  = '0;
      if (elig[0]) begin
         gnt = 3'b001;
         gi  = 2'd0;
      end else if (elig[1]) begin
         gnt = 3'b010;
         gi  = 2'd1;
      end else if (elig[2]) begin
         gnt = 3'b100;
         gi  = 2'd2;
      end
   end
`endif

   assign sel_x    = req_x[8*gi +: 8];
   assign sel_y    = req_y[7*gi +: 7];
   assign sel_c    = req_colour[COLOUR_W*gi +: COLOUR_W];
   assign in_range = (sel_x <= X_MAX) && (sel_y <= Y_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         ack        <= '0;
         x          <= '0;
         y          <= '0;
         colour     <= '0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         ack        <= '0;
         plot       <= 1'b0;
         clear_done <= 1'b0;
         case (state)
            S_CLEAR: begin
               // x/y double as the sweep counters
               if (x == X_MAX && y == Y_MAX) begin
                  state      <= S_DONE;
                  busy       <= 1'b0;
                  clear_done <= 1'b1;
               end else begin
                  plot <= 1'b1;
                  if (x == X_MAX) begin
                     x <= '0;
                     y <= y + 7'd1;
                  end else begin
                     x <= x + 8'd1;
                  end
               end
            end
            default: begin
               if (state == S_IDLE && clr_start) begin
                  state  <= S_CLEAR;
                  busy   <= 1'b1;
                  plot   <= 1'b1;
                  x      <= '0;
                  y      <= '0;
                  colour <= '0;
               end else begin
                  state <= S_IDLE;
                  if (|gnt) begin
                     ack <= gnt;
                     if (in_range) begin
                        plot   <= 1'b1;
                        x      <= sel_x;
                        y      <= sel_y;
                        colour <= sel_c;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule
